// File: rtl/alu_pkg.sv
`default_nettype none
//==============================================================================
// alu_pkg
//------------------------------------------------------------------------------
// Definitions shared by the ALU and its result stage: the opcodes that need
// special handling downstream (wide results), the writeback target encoding,
// and the result stage FSM state type.
//------------------------------------------------------------------------------
// Revision: 1.0 - initial release
//==============================================================================
package alu_pkg;

   localparam logic [4:0] OP_MUL = 5'b01110;
   localparam logic [4:0] OP_DIV = 5'b01111;

   typedef enum logic [1:0] {
      TGT_GPR = 2'd0,
      TGT_LO  = 2'd1,
      TGT_HI  = 2'd2
   } wb_target_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WB_GPR = 2'd1,
      WB_LO  = 2'd2,
      WB_HI  = 2'd3
   } rs_state_t;

   // mul/div return a double-width result that retires as a LO/HI beat pair.
   function automatic logic is_wide_op(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
//==============================================================================
// alu_result_stage
//------------------------------------------------------------------------------
// Captures the double-width ALU result and streams it to the register file as
// writeback beats over a valid/ready handshake. Single-word ops produce one
// GPR beat; mul/div produce a LO beat then a HI beat and update the
// architectural HI/LO registers held here.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   z_in, opcode,     ALU result, producing opcode and destination register,
//   dest, issue_valid qualified by issue_valid
//   issue_ready       stage idle and able to accept an issue
//   flush             synchronous abort of any pending beats
//   wb_valid/ready    writeback beat handshake
//   wb_data, wb_dest, beat payload (wb_target: 0 GPR, 1 LO, 2 HI)
//   wb_target
//   lo_q, hi_q        architectural LO/HI
//   retire_cnt        number of completed operations (wrapping)
//------------------------------------------------------------------------------
// Revision: 1.0 - initial release
//==============================================================================
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_W  = 4,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [2*DATA_W-1:0] z_in,
   input  logic [4:0]          opcode,
   input  logic [REG_W-1:0]    dest,
   input  logic                issue_valid,
   output logic                issue_ready,
   input  logic                flush,
   output logic                wb_valid,
   input  logic                wb_ready,
   output logic [DATA_W-1:0]   wb_data,
   output logic [REG_W-1:0]    wb_dest,
   output logic [1:0]          wb_target,
   output logic [DATA_W-1:0]   lo_q,
   output logic [DATA_W-1:0]   hi_q,
   output logic [CNT_W-1:0]    retire_cnt
);

   rs_state_t           r_state;
   rs_state_t           w_state_nx;
   logic [DATA_W-1:0]   r_zlo;
   logic [DATA_W-1:0]   r_zhi;
   logic [REG_W-1:0]    r_dest;
   logic                r_is_div;
   logic [DATA_W-1:0]   r_lo;
   logic [DATA_W-1:0]   r_hi;
   logic [CNT_W-1:0]    r_retire;

   logic                w_accept;
   logic                w_commit;

   assign issue_ready = (r_state == IDLE) && !flush;
   assign w_accept    = issue_valid && issue_ready;
   assign wb_valid    = (r_state != IDLE);
   // A beat handshaking alongside flush is dropped, so nothing is committed.
   assign w_commit    = wb_valid && wb_ready && !flush;

   assign lo_q        = r_lo;
   assign hi_q        = r_hi;
   assign retire_cnt  = r_retire;

   // Next state
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nx = is_wide_op(opcode) ? WB_LO : WB_GPR;
         WB_GPR:  if (wb_ready) w_state_nx = IDLE;
         WB_LO:   if (wb_ready) w_state_nx = WB_HI;
         WB_HI:   if (wb_ready) w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
      if (flush) w_state_nx = IDLE;
   end

   // Beat payload. Outputs depend only on registered state, so they hold
   // steady while the register file applies backpressure. div returns the
   // quotient in the upper half, which architecturally belongs in LO.
   always_comb begin
      wb_data   = '0;
      wb_dest   = '0;
      wb_target = TGT_GPR;
      case (r_state)
         WB_GPR: begin
            wb_data   = r_zlo;
            wb_dest   = r_dest;
            wb_target = TGT_GPR;
         end
         WB_LO: begin
            wb_data   = r_is_div ? r_zhi : r_zlo;
            wb_dest   = r_dest;
            wb_target = TGT_LO;
         end
         WB_HI: begin
            wb_data   = r_is_div ? r_zlo : r_zhi;
            wb_dest   = r_dest;
            wb_target = TGT_HI;
         end
         default: begin
            wb_data   = '0;
            wb_dest   = '0;
            wb_target = TGT_GPR;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_zlo    <= '0;
         r_zhi    <= '0;
         r_dest   <= '0;
         r_is_div <= 1'b0;
         r_lo     <= '0;
         r_hi     <= '0;
         r_retire <= '0;
      end else begin
         r_state <= w_state_nx;
         if (w_accept) begin
            r_zlo    <= z_in[DATA_W-1:0];
            r_zhi    <= z_in[2*DATA_W-1:DATA_W];
            r_dest   <= dest;
            r_is_div <= (opcode == OP_DIV);
         end
         if (w_commit && (r_state == WB_LO)) r_lo <= wb_data;
         if (w_commit && (r_state == WB_HI)) r_hi <= wb_data;
         if (w_commit && ((r_state == WB_GPR) || (r_state == WB_HI)))
            r_retire <= r_retire + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
//==============================================================================
// tb_alu_result_stage
//------------------------------------------------------------------------------
// Self-checking bench for alu_result_stage: vector table, directed corner
// sequences and a randomized run against a beat-queue reference model.
//------------------------------------------------------------------------------
// Revision: 1.0 - initial release
//==============================================================================
module tb_alu_result_stage;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] z_in;
   logic [4:0]  opcode;
   logic [3:0]  dest;
   logic        issue_valid;
   logic        issue_ready;
   logic        flush;
   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] wb_data;
   logic [3:0]  wb_dest;
   logic [1:0]  wb_target;
   logic [31:0] lo_q;
   logic [31:0] hi_q;
   logic [15:0] retire_cnt;

   int checks   = 0;
   int failures = 0;
   logic [15:0] exp_cnt;

   always #5 clk = ~clk;

   alu_result_stage #(.DATA_W(32), .REG_W(4), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .z_in(z_in), .opcode(opcode), .dest(dest),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .flush(flush),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
      .wb_dest(wb_dest), .wb_target(wb_target), .lo_q(lo_q), .hi_q(hi_q),
      .retire_cnt(retire_cnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [4:0]  op;
      logic [63:0] z;
      logic [3:0]  d;
      int          nb;
      logic [31:0] bd0;
      logic [1:0]  bt0;
      logic [31:0] bd1;
      logic [1:0]  bt1;
      logic [31:0] lo;
      logic [31:0] hi;
   } vec_t;

   // Issue one op with wb_ready held high and check every beat and the
   // architectural state afterwards.
   task automatic run_op(input vec_t v);
      @(negedge clk);
      chk("issue_ready_idle", issue_ready, 1);
      issue_valid = 1; opcode = v.op; z_in = v.z; dest = v.d; wb_ready = 1;
      @(negedge clk);
      issue_valid = 0;
      for (int b = 0; b < v.nb; b++) begin
         chk("beat_valid", wb_valid, 1);
         chk("beat_issue_ready", issue_ready, 0);
         chk("beat_data", wb_data, (b == 0) ? v.bd0 : v.bd1);
         chk("beat_target", wb_target, (b == 0) ? v.bt0 : v.bt1);
         if (((b == 0) ? v.bt0 : v.bt1) == TGT_GPR) chk("beat_dest", wb_dest, v.d);
         @(negedge clk);
      end
      exp_cnt = exp_cnt + 16'd1;
      chk("done_valid", wb_valid, 0);
      chk("done_lo", lo_q, v.lo);
      chk("done_hi", hi_q, v.hi);
      chk("done_cnt", retire_cnt, exp_cnt);
   endtask

   // Reference model: pending writeback beats as a queue.
   typedef struct {
      logic [31:0] data;
      logic [1:0]  tgt;
      logic [3:0]  d;
   } beat_t;

   beat_t       mq[$];
   logic [31:0] m_lo, m_hi;
   logic [15:0] m_cnt;

   task automatic model_issue(input logic [4:0] op, input logic [63:0] z, input logic [3:0] d);
      beat_t b0, b1;
      b0.d = d; b1.d = d;
      if (op == OP_MUL) begin
         b0.data = z[31:0];  b0.tgt = TGT_LO;
         b1.data = z[63:32]; b1.tgt = TGT_HI;
         mq.push_back(b0); mq.push_back(b1);
      end else if (op == OP_DIV) begin
         b0.data = z[63:32]; b0.tgt = TGT_LO;  // quotient
         b1.data = z[31:0];  b1.tgt = TGT_HI;  // remainder
         mq.push_back(b0); mq.push_back(b1);
      end else begin
         b0.data = z[31:0];  b0.tgt = TGT_GPR;
         mq.push_back(b0);
      end
   endtask

   vec_t vt[5];
   vec_t v;
   logic [31:0] held;

   initial begin
      reset = 1; z_in = '0; opcode = '0; dest = '0; issue_valid = 0;
      flush = 0; wb_ready = 0; exp_cnt = '0;

      vt[0] = '{5'b00000, 64'h0000_0000_0000_0007, 4'd5, 1, 32'h7, TGT_GPR, 32'h0, TGT_GPR,
                32'h0, 32'h0};
      vt[1] = '{OP_MUL, 64'h0000_0001_FFFF_FFFE, 4'd1, 2, 32'hFFFF_FFFE, TGT_LO, 32'h1, TGT_HI,
                32'hFFFF_FFFE, 32'h1};
      vt[2] = '{OP_DIV, 64'h0000_0003_0000_0002, 4'd2, 2, 32'h3, TGT_LO, 32'h2, TGT_HI,
                32'h3, 32'h2};
      vt[3] = '{5'b11111, 64'hAAAA_5555_0000_0009, 4'd15, 1, 32'h9, TGT_GPR, 32'h0, TGT_GPR,
                32'h3, 32'h2};
      vt[4] = '{OP_MUL, 64'h1234_5678_9ABC_DEF0, 4'd3, 2, 32'h9ABC_DEF0, TGT_LO, 32'h1234_5678,
                TGT_HI, 32'h9ABC_DEF0, 32'h1234_5678};

      // Reset state
      @(negedge clk); @(negedge clk);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_wb_dest", wb_dest, 0);
      chk("rst_wb_target", wb_target, 0);
      chk("rst_lo", lo_q, 0);
      chk("rst_hi", hi_q, 0);
      chk("rst_cnt", retire_cnt, 0);
      reset = 0;
      #1 chk("rst_issue_ready", issue_ready, 1);

      for (int i = 0; i < 5; i++) run_op(vt[i]);

      // Backpressure on a GPR beat
      @(negedge clk);
      issue_valid = 1; opcode = 5'b00001; z_in = 64'hFFFF_0000_CAFE_F00D; dest = 4'd9; wb_ready = 0;
      @(negedge clk);
      issue_valid = 0;
      held = 32'hCAFE_F00D;
      for (int k = 0; k < 3; k++) begin
         chk("bp_valid", wb_valid, 1);
         chk("bp_data", wb_data, held);
         chk("bp_issue_ready", issue_ready, 0);
         @(negedge clk);
      end
      wb_ready = 1;
      #1 chk("bp_release_data", wb_data, held);
      @(negedge clk);
      exp_cnt = exp_cnt + 16'd1;
      chk("bp_done_valid", wb_valid, 0);
      chk("bp_done_cnt", retire_cnt, exp_cnt);

      // Flush in WB_HI after LO has committed; same-cycle issue ignored
      issue_valid = 1; opcode = OP_MUL; z_in = 64'h0000_00AA_0000_00BB; dest = 4'd4;
      @(negedge clk);
      issue_valid = 0;
      chk("fl_lo_beat", wb_data, 32'hBB);
      @(negedge clk);
      chk("fl_in_hi", wb_target, TGT_HI);
      flush = 1; issue_valid = 1; opcode = 5'b00000; z_in = 64'h55;
      #1 chk("fl_issue_ready", issue_ready, 0);
      @(negedge clk);
      flush = 0; issue_valid = 0;
      chk("fl_idle", wb_valid, 0);
      chk("fl_lo", lo_q, 32'hBB);
      chk("fl_hi", hi_q, 32'h1234_5678);
      chk("fl_cnt", retire_cnt, exp_cnt);
      @(negedge clk);
      chk("fl_no_issue", wb_valid, 0);

      // Asynchronous reset mid WB_LO
      wb_ready = 0;
      issue_valid = 1; opcode = OP_DIV; z_in = 64'h0000_0011_0000_0022; dest = 4'd6;
      @(negedge clk);
      issue_valid = 0;
      chk("ar_in_lo", wb_target, TGT_LO);
      reset = 1;
      #1;
      chk("ar_valid", wb_valid, 0);
      chk("ar_data", wb_data, 0);
      chk("ar_lo", lo_q, 0);
      chk("ar_hi", hi_q, 0);
      chk("ar_cnt", retire_cnt, 0);
      @(negedge clk);
      reset = 0;
      exp_cnt = '0;
      v = '{5'b00000, 64'h0000_0000_0000_0042, 4'd7, 1, 32'h42, TGT_GPR, 32'h0, TGT_GPR,
            32'h0, 32'h0};
      run_op(v);

      // Retire counter wrap
      @(negedge clk);
      force dut.r_retire = 16'hFFFF;
      @(negedge clk);
      release dut.r_retire;
      @(negedge clk);
      chk("wrap_preload", retire_cnt, 16'hFFFF);
      exp_cnt = 16'hFFFF;
      run_op(v);
      chk("wrap_zero", retire_cnt, 16'h0000);

      // Randomized run against the beat-queue model
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      mq.delete(); m_lo = '0; m_hi = '0; m_cnt = '0;
      for (int c = 0; c < 4000; c++) begin
         logic acc, hs, ok;
         @(negedge clk);
         issue_valid = ($urandom_range(0, 1) == 1);
         case ($urandom_range(0, 3))
            0: opcode = OP_MUL;
            1: opcode = OP_DIV;
            default: opcode = 5'($urandom);
         endcase
         z_in     = {$urandom, $urandom};
         dest     = 4'($urandom);
         wb_ready = ($urandom_range(0, 9) < 7);
         flush    = ($urandom_range(0, 19) == 0);
         #1;
         ok = 1;
         if (issue_ready !== ((mq.size() == 0) && !flush)) ok = 0;
         if (wb_valid !== (mq.size() != 0)) ok = 0;
         if (mq.size() != 0) begin
            if (wb_data !== mq[0].data) ok = 0;
            if (wb_target !== mq[0].tgt) ok = 0;
            if ((mq[0].tgt == TGT_GPR) && (wb_dest !== mq[0].d)) ok = 0;
         end
         if (lo_q !== m_lo || hi_q !== m_hi || retire_cnt !== m_cnt) ok = 0;
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL rand_cycle%0d actual v=%b d=%h t=%0d lo=%h hi=%h cnt=%h expected v=%b lo=%h hi=%h cnt=%h",
                     c, wb_valid, wb_data, wb_target, lo_q, hi_q, retire_cnt,
                     (mq.size() != 0), m_lo, m_hi, m_cnt);
         end
         acc = issue_valid && (mq.size() == 0) && !flush;
         hs  = (mq.size() != 0) && wb_ready && !flush;
         @(posedge clk);
         if (flush) begin
            mq.delete();
         end else if (acc) begin
            model_issue(opcode, z_in, dest);
         end else if (hs) begin
            beat_t b;
            b = mq.pop_front();
            if (b.tgt == TGT_LO) m_lo = b.data;
            if (b.tgt == TGT_HI) m_hi = b.data;
            if (b.tgt != TGT_LO) m_cnt = m_cnt + 16'd1;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
